shift8_unit: RTL and testbench
==============================

// Module: shift8_unit
// PURPOSE
//   Registered 8-bit shift unit for the ALU datapath. Computes logical-left, logical-right and
//   arithmetic-right shifts of one operand by a 3-bit amount in parallel. All three results are
//   captured in output registers, so results appear one clock after the input is accepted.
// PARAMETERS
//   WIDTH    8   operand/result width; only 8 is supported
//   SHAMT_W  3   shift-amount width, equal to clog2(WIDTH); not overridable
// PORTS
//   clk       in   1  single clock; all state updates on rising edge
//   rst       in   1  synchronous, active-high reset
//   in_valid  in   1  operand accept strobe
//   a         in   8  operand
//   shamt     in   3  shift amount, 0..7, unsigned
//   y_sll     out  8  registered a << shamt, zero fill
//   y_srl     out  8  registered a >> shamt, zero fill
//   y_sra     out  8  registered a >>> shamt, fill with a[7]
//   y_rol     out  8  registered rotate-left (see CONFIGURATION)
//   y_ror     out  8  registered rotate-right (see CONFIGURATION)
//   out_valid out  1  high the cycle after an accepted input
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): all y_* = 8'h00, out_valid = 0. rst has priority over in_valid.
//   - Edge with in_valid=1: all y_* load the results for the current a/shamt; out_valid <= 1.
//   - Edge with in_valid=0: y_* hold their values; out_valid <= 0.
//   - Latency is exactly 1 cycle. There is no backpressure; back-to-back inputs give
//     back-to-back results.
//   - shamt=0: every output equals a.
//   - shamt=7: sll gives {a[0],7'b0}; srl gives {7'b0,a[7]}; sra gives {8{a[7]}}.
//   - sra with a[7]=0 equals srl for every shamt.
//   - No overflow, carry or status flags; bits shifted out are discarded.
//   - No X propagation: outputs are fully defined from reset onward.
// CONFIGURATION
//   SHIFT8_ROTATE_EN defined:
//     y_rol = rotate a left by shamt; y_ror = rotate a right by shamt.
//     Both are registered with the same timing as the other outputs.
//   SHIFT8_ROTATE_EN undefined:
//     y_rol and y_ror are tied to 8'h00 and no rotate logic is built.
//     The ports remain present in both builds.
// STRUCTURE
//   - Package shift8_pkg holds:
//     - WIDTH and SHAMT_W constants;
//     - a typedef for shift mode {SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR}.
//   - Sub-module shift8_barrel: combinational logarithmic shifter.
//     - Three stages: shift by 1, 2 and 4, each selected by one shamt bit.
//     - Mode input selects direction and fill source: 0, a[7], or the wrapped bits.
//   - shift8_unit instantiates one shift8_barrel per mode in parallel and adds the output
//     registers plus valid logic.
// TESTING
//   - Reset: assert rst for 2 cycles with in_valid=1 -> all y_* = 00 and out_valid = 0
//     throughout.
//   - a=B3, sweep shamt 0..7, one per cycle:
//     - y_sll = B3,66,CC,98,30,60,C0,80
//     - y_srl = B3,59,2C,16,0B,05,02,01
//     - y_sra = B3,D9,EC,F6,FB,FD,FE,FF
//     - each result appears 1 cycle after its input.
//   - a=CA, shamt 0..3:
//     - y_sll = CA,94,28,50
//     - y_srl = CA,65,32,19
//     - y_sra = CA,E5,F2,F9
//   - Hold: load a=B3,shamt=3, then drop in_valid and change a/shamt -> outputs stay
//     98/16/F6 and out_valid falls.
//   - With SHIFT8_ROTATE_EN, a=B3:
//     - shamt=1 -> y_rol=67, y_ror=D9
//     - shamt=4 -> y_rol=3B, y_ror=3B
//     - without the macro, y_rol = y_ror = 00 always.
//   - Random: 1000 random a/shamt/in_valid values checked against a reference model,
//     including rst asserted mid-stream, which must clear all outputs on the next edge.

Source files
------------

// File: rtl/shift8_pkg.sv
// Shared constants and shift-mode encoding for the 8-bit shift unit.
package shift8_pkg;
  localparam int WIDTH   = 8;
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA,
    SH_ROL,
    SH_ROR
  } shift_mode_t;
endpackage

// File: rtl/shift8_if.sv
// Operand/result bundle for shift8_unit; master drives operands, slave returns registered results.
interface shift8_if;
  import shift8_pkg::*;

  logic               in_valid;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   y_sll;
  logic [WIDTH-1:0]   y_srl;
  logic [WIDTH-1:0]   y_sra;
  logic [WIDTH-1:0]   y_rol;
  logic [WIDTH-1:0]   y_ror;
  logic               out_valid;

  modport master (
    output in_valid, a, shamt,
    input  y_sll, y_srl, y_sra, y_rol, y_ror, out_valid
  );

  modport slave (
    input  in_valid, a, shamt,
    output y_sll, y_srl, y_sra, y_rol, y_ror, out_valid
  );
endinterface

// File: rtl/shift8_barrel.sv
// Combinational log shifter (stages 1/2/4), fill chosen by mode: zero, sign, or wrapped bits.
// Zero latency; no handshake, purely combinational.
module shift8_barrel
  import shift8_pkg::*;
(
  input  shift_mode_t        mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   y
);

  logic [WIDTH-1:0] stg [SHAMT_W+1];

  assign stg[0] = a;

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int N = 1 << s;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] nxt;
    logic [N-1:0]     fill_l;
    logic [N-1:0]     fill_r;
    logic             left;

    always_comb begin
      cur    = stg[s];
      fill_l = '0;
      fill_r = '0;
      left   = (mode == SH_SLL) || (mode == SH_ROL);
      case (mode)
        SH_SRA:  fill_r = {N{a[WIDTH-1]}};
        SH_ROL:  fill_l = cur[WIDTH-1 -: N];
        SH_ROR:  fill_r = cur[N-1:0];
        default: ;
      endcase
      shl = {cur[WIDTH-N-1:0], fill_l};
      shr = {fill_r, cur[WIDTH-1:N]};
      nxt = shamt[s] ? (left ? shl : shr) : cur;
    end

    assign stg[s+1] = nxt;
  end

  assign y = stg[SHAMT_W];

endmodule

// File: rtl/shift8_unit.sv
// Registered 8-bit shifter (sll/srl/sra, plus rol/ror when SHIFT8_ROTATE_EN is defined).
// One-cycle latency, no backpressure: every in_valid beat yields a result the next cycle.
module shift8_unit
  import shift8_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  shift8_if.slave  bus
);

  logic [WIDTH-1:0] res_sll;
  logic [WIDTH-1:0] res_srl;
  logic [WIDTH-1:0] res_sra;

  shift8_barrel u_sll (.mode(SH_SLL), .a(bus.a), .shamt(bus.shamt), .y(res_sll));
  shift8_barrel u_srl (.mode(SH_SRL), .a(bus.a), .shamt(bus.shamt), .y(res_srl));
  shift8_barrel u_sra (.mode(SH_SRA), .a(bus.a), .shamt(bus.shamt), .y(res_sra));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_sll     <= '0;
      bus.y_srl     <= '0;
      bus.y_sra     <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.y_sll <= res_sll;
        bus.y_srl <= res_srl;
        bus.y_sra <= res_sra;
      end
    end
  end

`ifdef SHIFT8_ROTATE_EN
  logic [WIDTH-1:0] res_rol;
  logic [WIDTH-1:0] res_ror;

  shift8_barrel u_rol (.mode(SH_ROL), .a(bus.a), .shamt(bus.shamt), .y(res_rol));
  shift8_barrel u_ror (.mode(SH_ROR), .a(bus.a), .shamt(bus.shamt), .y(res_ror));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_rol <= '0;
      bus.y_ror <= '0;
    end else if (bus.in_valid) begin
      bus.y_rol <= res_rol;
      bus.y_ror <= res_ror;
    end
  end
`else
  assign bus.y_rol = '0;
  assign bus.y_ror = '0;
`endif

endmodule

// File: tb/tb_shift8_unit.sv
// Directed + random bench for shift8_unit; drives on negedge, samples 1 time unit after posedge.
module tb_shift8_unit;
  import shift8_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  // Reference state: what the output registers should hold after the latest edge.
  logic [7:0] m_sll = '0, m_srl = '0, m_sra = '0, m_rol = '0, m_ror = '0;
  logic       m_vld = 1'b0;

  shift8_if bus ();
  shift8_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] f_rol(input logic [7:0] a, input logic [2:0] s);
    logic [15:0] d;
    d = {a, a} << s;
    return d[15:8];
  endfunction

  function automatic logic [7:0] f_ror(input logic [7:0] a, input logic [2:0] s);
    logic [15:0] d;
    d = {a, a} >> s;
    return d[7:0];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] av, input logic [2:0] sv);
    logic signed [7:0] sa;
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.a        = av;
    bus.shamt    = sv;
    sa = $signed(av);
    if (r) begin
      {m_sll, m_srl, m_sra, m_rol, m_ror} = '0;
      m_vld = 1'b0;
    end else begin
      m_vld = v;
      if (v) begin
        m_sll = av << sv;
        m_srl = av >> sv;
        m_sra = sa >>> sv;
`ifdef SHIFT8_ROTATE_EN
        m_rol = f_rol(av, sv);
        m_ror = f_ror(av, sv);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rot(input string tag);
    chk({tag, ".rol"}, bus.y_rol, m_rol);
    chk({tag, ".ror"}, bus.y_ror, m_ror);
  endtask

  logic [7:0] t_b3_sll [8] = '{8'hB3, 8'h66, 8'hCC, 8'h98, 8'h30, 8'h60, 8'hC0, 8'h80};
  logic [7:0] t_b3_srl [8] = '{8'hB3, 8'h59, 8'h2C, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01};
  logic [7:0] t_b3_sra [8] = '{8'hB3, 8'hD9, 8'hEC, 8'hF6, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
  logic [7:0] t_ca_sll [4] = '{8'hCA, 8'h94, 8'h28, 8'h50};
  logic [7:0] t_ca_srl [4] = '{8'hCA, 8'h65, 8'h32, 8'h19};
  logic [7:0] t_ca_sra [4] = '{8'hCA, 8'hE5, 8'hF2, 8'hF9};

  initial begin
    bus.in_valid = 1'b1;
    bus.a        = 8'hB3;
    bus.shamt    = 3'd1;

    // Reset held two cycles with in_valid high must keep everything cleared.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 8'hB3, 3'd1);
      chk("rst.sll", bus.y_sll, 8'h00);
      chk("rst.srl", bus.y_srl, 8'h00);
      chk("rst.sra", bus.y_sra, 8'h00);
      chk("rst.rol", bus.y_rol, 8'h00);
      chk("rst.ror", bus.y_ror, 8'h00);
      chk("rst.vld", {7'b0, bus.out_valid}, 8'h00);
    end

    for (int s = 0; s < 8; s++) begin
      step(1'b0, 1'b1, 8'hB3, 3'(s));
      chk($sformatf("b3.sll[%0d]", s), bus.y_sll, t_b3_sll[s]);
      chk($sformatf("b3.srl[%0d]", s), bus.y_srl, t_b3_srl[s]);
      chk($sformatf("b3.sra[%0d]", s), bus.y_sra, t_b3_sra[s]);
      chk($sformatf("b3.vld[%0d]", s), {7'b0, bus.out_valid}, 8'h01);
      chk_rot($sformatf("b3[%0d]", s));
`ifdef SHIFT8_ROTATE_EN
      if (s == 1) begin
        chk("b3.rol1", bus.y_rol, 8'h67);
        chk("b3.ror1", bus.y_ror, 8'hD9);
      end
      if (s == 4) begin
        chk("b3.rol4", bus.y_rol, 8'h3B);
        chk("b3.ror4", bus.y_ror, 8'h3B);
      end
`else
      chk("b3.rol0", bus.y_rol, 8'h00);
      chk("b3.ror0", bus.y_ror, 8'h00);
`endif
    end

    for (int s = 0; s < 4; s++) begin
      step(1'b0, 1'b1, 8'hCA, 3'(s));
      chk($sformatf("ca.sll[%0d]", s), bus.y_sll, t_ca_sll[s]);
      chk($sformatf("ca.srl[%0d]", s), bus.y_srl, t_ca_srl[s]);
      chk($sformatf("ca.sra[%0d]", s), bus.y_sra, t_ca_sra[s]);
      chk_rot($sformatf("ca[%0d]", s));
    end

    // Load, then drop in_valid while changing operands: results must hold.
    step(1'b0, 1'b1, 8'hB3, 3'd3);
    chk("hold.load.sll", bus.y_sll, 8'h98);
    chk("hold.load.vld", {7'b0, bus.out_valid}, 8'h01);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'h5C + 8'(i), 3'd6 - 3'(i));
      chk("hold.sll", bus.y_sll, 8'h98);
      chk("hold.srl", bus.y_srl, 8'h16);
      chk("hold.sra", bus.y_sra, 8'hF6);
      chk("hold.vld", {7'b0, bus.out_valid}, 8'h00);
      chk_rot("hold");
    end

    for (int i = 0; i < 1000; i++) begin
      step((i == 500) || ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
           8'($urandom), 3'($urandom));
      chk("rnd.sll", bus.y_sll, m_sll);
      chk("rnd.srl", bus.y_srl, m_srl);
      chk("rnd.sra", bus.y_sra, m_sra);
      chk("rnd.rol", bus.y_rol, m_rol);
      chk("rnd.ror", bus.y_ror, m_ror);
      chk("rnd.vld", {7'b0, bus.out_valid}, {7'b0, m_vld});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
